// File: rtl/axis_rr_fifo_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between N_SRC AXI-Stream sources.
// Define ARB_TLAST_EN for packet mode, where a grant is released only by a tlast beat.
module axis_rr_fifo_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC-1:0]            s_axis_tvalid,
    output logic [N_SRC-1:0]            s_axis_tready,
    input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
`ifdef ARB_TLAST_EN
    input  logic [N_SRC-1:0]            s_axis_tlast,
    output logic                        m_axis_tlast,
`endif
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [ID_WIDTH-1:0]         m_axis_tid,
    output logic                        grant_active
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [ID_WIDTH-1:0] grant_id_reg, grant_id_next;
    logic [ID_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
    logic [7:0]          burst_cnt_reg, burst_cnt_next;

    logic [DATA_WIDTH-1:0] src_data [N_SRC];

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_slice
            assign src_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            grant_id_reg  <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_id_reg  <= grant_id_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    always_comb begin
        logic                sel_valid;
        logic                beat;
        logic                release_now;
        logic [ID_WIDTH-1:0] ptr_after;
        logic [ID_WIDTH-1:0] scan_base;
        logic [ID_WIDTH-1:0] idx;
        logic [ID_WIDTH-1:0] pick;
        logic                found;

        sel_valid = s_axis_tvalid[grant_id_reg];
        beat      = (state_reg == GRANT) && sel_valid && m_axis_tready;
`ifdef ARB_TLAST_EN
        release_now = beat && s_axis_tlast[grant_id_reg];
`else
        release_now = (state_reg == GRANT) &&
                      (!sel_valid || (beat && burst_cnt_reg == 8'(MAX_BURST - 1)));
`endif
        ptr_after = (grant_id_reg == ID_WIDTH'(N_SRC - 1)) ? '0 : grant_id_reg + ID_WIDTH'(1);

        // On release the scan starts just past the released source, so it is reached last.
        scan_base = (state_reg == GRANT) ? ptr_after : rr_ptr_reg;
        found     = 1'b0;
        pick      = '0;
        idx       = scan_base;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && s_axis_tvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = (idx == ID_WIDTH'(N_SRC - 1)) ? '0 : idx + ID_WIDTH'(1);
        end

        state_next     = state_reg;
        grant_id_next  = grant_id_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next    = GRANT;
                    grant_id_next = pick;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_ptr_next    = ptr_after;
                    burst_cnt_next = '0;
                    if (found) grant_id_next = pick;
                    else       state_next    = IDLE;
                end else if (beat) begin
`ifdef ARB_TLAST_EN
                    if (burst_cnt_reg != 8'hFF) burst_cnt_next = burst_cnt_reg + 8'd1;
`else
                    burst_cnt_next = burst_cnt_reg + 8'd1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath is purely combinational from the registered grant.
    always_comb begin
        logic is_grant;
        is_grant      = (state_reg == GRANT);
        grant_active  = is_grant;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tid    = '0;
        s_axis_tready = '0;
`ifdef ARB_TLAST_EN
        m_axis_tlast  = 1'b0;
`endif
        if (is_grant) begin
            m_axis_tvalid               = s_axis_tvalid[grant_id_reg];
            m_axis_tdata                = src_data[grant_id_reg];
            m_axis_tid                  = grant_id_reg;
            s_axis_tready[grant_id_reg] = m_axis_tready;
`ifdef ARB_TLAST_EN
            m_axis_tlast                = s_axis_tlast[grant_id_reg];
`endif
        end
    end

endmodule

// File: tb/tb_axis_rr_fifo_arbiter.sv
// Directed bench for axis_rr_fifo_arbiter: modelled sources, a depth-4 FIFO ready model
// and a scoreboard of expected (data, tid) beats.
module tb_axis_rr_fifo_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  s_axis_tvalid;
    logic [N-1:0]  s_axis_tready;
    logic [N*DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [IW-1:0] m_axis_tid;
    logic          grant_active;
`ifdef ARB_TLAST_EN
    logic [N-1:0]  s_axis_tlast;
    logic          m_axis_tlast;
`endif

    always #5 clk = ~clk;

    axis_rr_fifo_arbiter #(
        .N_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
`ifdef ARB_TLAST_EN
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tlast  (m_axis_tlast),
`endif
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tid    (m_axis_tid),
        .grant_active  (grant_active)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] tid;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] src_mem      [N][64];
    logic          src_last_mem [N][64];
    int            src_head [N];
    int            src_tail [N];
    int            total = 0;
    int            bad   = 0;
    int            fifo_cnt = 0;
    bit            drain = 1'b1;
    logic          last_ga, last_beat, last_mv;
    logic [IW-1:0] last_tid;
    logic [N-1:0]  last_sready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input int s, input int idx);
        return DW'(s * 4096 + idx + 1);
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i]         = (src_head[i] < src_tail[i]);
            s_axis_tdata[i*DW +: DW] = s_axis_tvalid[i] ? src_mem[i][src_head[i]] : '0;
`ifdef ARB_TLAST_EN
            s_axis_tlast[i]          = s_axis_tvalid[i] && src_last_mem[i][src_head[i]];
`endif
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic load(input int s, input int n, input bit last_end);
        for (int j = 0; j < n; j++) begin
            src_mem[s][src_tail[s]]      = data_of(s, src_tail[s]);
            src_last_mem[s][src_tail[s]] = last_end && (j == n - 1);
            src_tail[s]++;
        end
    endtask

    task automatic push_exp(input int s, input int from, input int n, input int last_idx);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.data = data_of(s, from + j);
            e.tid  = IW'(s);
            e.last = (from + j == last_idx);
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample at negedge, advance sources and FIFO model just after posedge.
    task automatic tick();
        logic [N-1:0] hs;
        exp_t         e;
        @(negedge clk);
        hs          = s_axis_tvalid & s_axis_tready;
        last_ga     = grant_active;
        last_mv     = m_axis_tvalid;
        last_tid    = m_axis_tid;
        last_sready = s_axis_tready;
        last_beat   = rst && m_axis_tvalid && m_axis_tready;
        if (last_beat) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", m_axis_tdata, e.data);
                chk("beat_tid", m_axis_tid, e.tid);
`ifdef ARB_TLAST_EN
                chk("beat_tlast", m_axis_tlast, e.last);
`endif
                $display("beat tid=%0d data=%04h", m_axis_tid, m_axis_tdata);
            end
            if (!drain) fifo_cnt++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) src_head[i]++;
        drive_sources();
        m_axis_tready = drain || (fifo_cnt < 4);
    endtask

    // Asynchronous assertion away from any edge; outputs must clear at once.
    task automatic do_reset();
        drain         = 1'b1;
        m_axis_tready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_async_ga", grant_active, 0);
        chk("rst_async_mvalid", m_axis_tvalid, 0);
        chk("rst_async_sready", s_axis_tready, 0);
        chk("rst_async_tid", m_axis_tid, 0);
        chk("rst_async_tdata", m_axis_tdata, 0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [N*DW-1:0] busy_data;
        busy_data     = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        s_axis_tvalid = '1;
        s_axis_tdata  = busy_data;
        m_axis_tready = 1'b1;
`ifdef ARB_TLAST_EN
        s_axis_tlast  = '1;
`endif
        // Reset held with every source requesting.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_mvalid", m_axis_tvalid, 0);
            chk("rst_sready", s_axis_tready, 0);
            chk("rst_tdata", m_axis_tdata, 0);
            chk("rst_tid", m_axis_tid, 0);
            chk("rst_ga", grant_active, 0);
        end
        @(posedge clk);
        #1;
        clear_sources();
        drive_sources();
        rst = 1'b1;
        tick();
        chk("idle_no_req", last_ga, 0);

        // Mid-burst reset: source keeps its data and resumes afterwards.
        clear_sources();
        load(0, 4, 1'b0);
        push_exp(0, 0, 4, -1);
        drive_sources();
        tick();
        chk("mr_arb", last_ga, 0);
        tick();
        tick();
        chk("mr_beat2", last_beat, 1);
        do_reset();
        tick();
        chk("mr_rearb", last_ga, 0);
        tick();
        chk("mr_resume3", last_beat, 1);
        tick();
        chk("mr_resume4", last_beat, 1);
        tick();
        chk("mr_done", last_beat, 0);

`ifndef ARB_TLAST_EN
        // Single source, burst limit release and immediate re-grant.
        do_reset();
        clear_sources();
        load(0, 10, 1'b0);
        push_exp(0, 0, 10, -1);
        drive_sources();
        tick();
        chk("t2_arb_latency", last_ga, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t2_ga", last_ga, 1);
            chk("t2_beat", last_beat, 1);
        end
        tick();
        chk("t2_drop", last_beat, 0);
        tick();
        chk("t2_idle", last_ga, 0);

        // Four continuous sources rotate in bursts of MB with no idle cycle.
        do_reset();
        clear_sources();
        for (int i = 0; i < N; i++) load(i, 2 * MB, 1'b0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_exp(i, r * MB, MB, -1);
        drive_sources();
        tick();
        chk("t3_arb", last_ga, 0);
        for (int k = 0; k < 2 * N * MB; k++) begin
            tick();
            chk("t3_no_idle", last_beat, 1);
        end
        tick();
        chk("t3_regrant_drop", last_beat, 0);
        tick();
        chk("t3_idle", last_ga, 0);

        // FIFO fills: grant and burst count hold while tready is low.
        do_reset();
        clear_sources();
        drain         = 1'b0;
        fifo_cnt      = 0;
        m_axis_tready = 1'b1;
        load(2, 12, 1'b0);
        push_exp(2, 0, MB, -1);
        push_exp(0, 0, 2, -1);
        push_exp(2, MB, 12 - MB, -1);
        drive_sources();
        tick();
        chk("t4_arb", last_ga, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_sready", last_sready, 4'b0100);
            chk("t4_tid", last_tid, 2);
        end
        load(0, 2, 1'b0);
        drive_sources();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t4_full_beat", last_beat, 0);
            chk("t4_full_ga", last_ga, 1);
            chk("t4_full_tid", last_tid, 2);
            chk("t4_full_mvalid", last_mv, 1);
            chk("t4_full_sready", last_sready, 0);
        end
        drain         = 1'b1;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        tick();
        chk("t4_idle", last_ga, 0);

        // tvalid drop ends a short burst; the waiting source follows at once.
        do_reset();
        clear_sources();
        load(1, 3, 1'b0);
        load(3, 4, 1'b0);
        push_exp(1, 0, 3, -1);
        push_exp(3, 0, 4, -1);
        drive_sources();
        tick();
        chk("t5_arb", last_ga, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_beat", last_beat, 1);
            chk("t5_tid1", last_tid, 1);
        end
        tick();
        chk("t5_drop_beat", last_beat, 0);
        chk("t5_drop_ga", last_ga, 1);
        tick();
        chk("t5_next_beat", last_beat, 1);
        chk("t5_tid3", last_tid, 3);
        for (int k = 0; k < 3; k++) tick();
        tick();
        tick();
        chk("t5_idle", last_ga, 0);
`else
        // Packet mode: a 12-beat packet is not cut at MB beats.
        do_reset();
        clear_sources();
        load(0, 12, 1'b1);
        load(1, 3, 1'b1);
        push_exp(0, 0, 12, 11);
        push_exp(1, 0, 3, 2);
        drive_sources();
        tick();
        chk("t6_arb", last_ga, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t6_beat0", last_beat, 1);
            chk("t6_tid0", last_tid, 0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_beat1", last_beat, 1);
            chk("t6_tid1", last_tid, 1);
        end
        tick();
        chk("t6_hold_ga", last_ga, 1);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
